// File: rtl/bus_arbiter_rr_pkg.sv
// Shared owner encoding and active-low grant helpers for the round-robin bus arbiter.
package bus_arbiter_rr_pkg;

  localparam int BUS_OWNER_W = 2;
  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Active-low one-cold grant vector, bit K belongs to master K.
  function automatic logic [3:0] grant_decode(input bus_owner_t owner);
    logic [3:0] grnt;
    grnt        = {4{DISABLE_}};
    grnt[owner] = ENABLE_;
    return grnt;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin scan: first requesting master after the current owner, wrapping mod 4.
module bus_arb_rr_pick
  import bus_arbiter_rr_pkg::*;
(
  input  logic [3:0] req_n,
  input  bus_owner_t owner,
  output bus_owner_t next_pick,
  output logic       others_req
);

  bus_owner_t idx;

  always_comb begin
    next_pick  = owner;
    others_req = 1'b0;
    idx        = owner;
    for (int i = 3; i >= 1; i--) begin
      // Scanned farthest-first so the nearest requester wins the last write.
      idx = owner + BUS_OWNER_W'(i);
      if (req_n[idx] == ENABLE_) begin
        next_pick  = idx;
        others_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Four-master round-robin bus arbiter with active-low handshakes and optional tenure limit.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int MAX_HOLD   = 0,
  parameter int HOLD_CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req_,
  input  logic             m1_req_,
  input  logic             m2_req_,
  input  logic             m3_req_,
  input  logic             m0_as_,
  input  logic             m1_as_,
  input  logic             m2_as_,
  input  logic             m3_as_,
  output logic             m0_grnt_,
  output logic             m1_grnt_,
  output logic             m2_grnt_,
  output logic             m3_grnt_,
  output logic [1:0]       owner,
  output logic             preempt
);

  localparam bit TENURE_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT =
    HOLD_CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  logic [3:0]            req_n;
  logic [3:0]            as_n;
  logic [3:0]            grnt_q;
  bus_owner_t            owner_q;
  bus_owner_t            next_pick;
  logic                  others_req;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  preempt_q;
  logic                  owner_req;
  logic                  owner_busy;
  logic                  expired;

  assign req_n = {m3_req_, m2_req_, m1_req_, m0_req_};
  assign as_n  = {m3_as_, m2_as_, m1_as_, m0_as_};

  bus_arb_rr_pick u_pick (
    .req_n      (req_n),
    .owner      (owner_q),
    .next_pick  (next_pick),
    .others_req (others_req)
  );

  assign owner_req  = (req_n[owner_q] == ENABLE_);
  assign owner_busy = (as_n[owner_q] == ENABLE_);
  assign expired    = TENURE_EN && (hold_cnt >= HOLD_LIMIT);

  // Grant lines are kept in their own flops, updated on the same edge as the
  // owner, so the slave mux select never sees decode hazards.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= BUS_OWNER_MASTER_0;
      grnt_q    <= grant_decode(BUS_OWNER_MASTER_0);
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      if (!owner_req && others_req) begin
        owner_q  <= next_pick;
        grnt_q   <= grant_decode(next_pick);
        hold_cnt <= '0;
      end else if (owner_req && others_req && expired && !owner_busy) begin
        owner_q   <= next_pick;
        grnt_q    <= grant_decode(next_pick);
        hold_cnt  <= '0;
        preempt_q <= 1'b1;
      end else if (owner_req && others_req) begin
        // Covers an expired tenure stalled by an access in flight as well.
        if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
  assign owner   = owner_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scoreboard bench for bus_arbiter_rr with a 4-cycle tenure limit.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_as_, m1_as_, m2_as_, m3_as_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] owner;
    logic       preempt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bus_arbiter_rr #(.MAX_HOLD(4), .HOLD_CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (m0_req_),
    .m1_req_  (m1_req_),
    .m2_req_  (m2_req_),
    .m3_req_  (m3_req_),
    .m0_as_   (m0_as_),
    .m1_as_   (m1_as_),
    .m2_as_   (m2_as_),
    .m3_as_   (m3_as_),
    .m0_grnt_ (m0_grnt_),
    .m1_grnt_ (m1_grnt_),
    .m2_grnt_ (m2_grnt_),
    .m3_grnt_ (m3_grnt_),
    .owner    (owner),
    .preempt  (preempt)
  );

  // req/busy are active-high here ({m3,m2,m1,m0}); expectations describe the
  // state visible one cycle after the edge that samples these inputs.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] busy,
                      input logic [1:0] exp_owner, input logic exp_pre, input string tag);
    exp_t e;
    exp_t got;
    logic [3:0] grnt;
    logic [3:0] exp_grnt;
    reset = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = ~req;
    {m3_as_, m2_as_, m1_as_, m0_as_}     = ~busy;
    e.owner   = exp_owner;
    e.preempt = exp_pre;
    e.tag     = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end
    if (sb.size() != 0) begin
      got      = sb.pop_front();
      grnt     = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
      exp_grnt = ~(4'b0001 << got.owner);
      checks++;
      assert (owner === got.owner) else begin
        failures++;
        $error("FAIL %s owner: got %0d expected %0d", got.tag, owner, got.owner);
      end
      checks++;
      assert (grnt === exp_grnt) else begin
        failures++;
        $error("FAIL %s grnt_: got %b expected %b", got.tag, grnt, exp_grnt);
      end
      checks++;
      assert (preempt === got.preempt) else begin
        failures++;
        $error("FAIL %s preempt: got %b expected %b", got.tag, preempt, got.preempt);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'hF;
    {m3_as_, m2_as_, m1_as_, m0_as_}     = 4'hF;

    step(1, 4'b0000, 4'b0000, 2'd0, 0, "reset0");
    step(1, 4'b0000, 4'b0000, 2'd0, 0, "reset1");
    for (int i = 0; i < 20; i++) step(0, 4'b0000, 4'b0000, 2'd0, 0, "park");

    // Simultaneous m2/m3 from owner 0: scan picks m2, then m3 on release.
    step(0, 4'b1100, 4'b0000, 2'd2, 0, "rr_m2_first");
    step(0, 4'b1000, 4'b0000, 2'd3, 0, "rel_to_m3");

    // Wrap scan: from owner 3, master 0 comes before master 1.
    step(0, 4'b0011, 4'b0000, 2'd0, 0, "wrap_to_m0");
    step(0, 4'b0010, 4'b0000, 2'd1, 0, "rel_to_m1");
    step(0, 4'b0010, 4'b0000, 2'd1, 0, "m1_alone");

    // Tenure expiry: m1 holds with m2 waiting, rotates after its 4th cycle.
    step(0, 4'b0110, 4'b0000, 2'd1, 0, "ten_c0");
    step(0, 4'b0110, 4'b0000, 2'd1, 0, "ten_c1");
    step(0, 4'b0110, 4'b0000, 2'd1, 0, "ten_c2");
    step(0, 4'b0110, 4'b0000, 2'd2, 1, "ten_expire");
    step(0, 4'b0110, 4'b0000, 2'd2, 0, "ten_pulse_end");
    step(0, 4'b0010, 4'b0000, 2'd1, 0, "back_to_m1");

    // Expiry stalled by m1 access in flight during cycles 3-6.
    step(0, 4'b0110, 4'b0000, 2'd1, 0, "as_c0");
    step(0, 4'b0110, 4'b0000, 2'd1, 0, "as_c1");
    step(0, 4'b0110, 4'b0000, 2'd1, 0, "as_c2");
    step(0, 4'b0110, 4'b0010, 2'd1, 0, "as_c3_held");
    step(0, 4'b0110, 4'b0010, 2'd1, 0, "as_c4_held");
    step(0, 4'b0110, 4'b0010, 2'd1, 0, "as_c5_held");
    step(0, 4'b0110, 4'b0010, 2'd1, 0, "as_c6_held");
    step(0, 4'b0110, 4'b0000, 2'd2, 1, "as_c7_rotate");
    step(0, 4'b0100, 4'b0000, 2'd2, 0, "as_pulse_end");

    // Reset in cycle 2 of an m2 tenure with m3 waiting.
    step(0, 4'b1100, 4'b0000, 2'd2, 0, "rst_ten_c0");
    step(0, 4'b1100, 4'b0000, 2'd2, 0, "rst_ten_c1");
    step(1, 4'b1100, 4'b0000, 2'd0, 0, "rst_mid");
    // A full 4-cycle tenure afterwards shows hold_cnt restarted from 0.
    step(0, 4'b1001, 4'b0000, 2'd0, 0, "post_rst_c0");
    step(0, 4'b1001, 4'b0000, 2'd0, 0, "post_rst_c1");
    step(0, 4'b1001, 4'b0000, 2'd0, 0, "post_rst_c2");
    step(0, 4'b1001, 4'b0000, 2'd3, 1, "post_rst_expire");
    step(0, 4'b0000, 4'b0000, 2'd3, 0, "idle_park");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
